req_grant_client: RTL and testbench

- Requester side of the 4-channel request/grant handshake used by the fixed-priority arbiter.
- Each channel queues incoming jobs, raises its `request` line, and waits for `grant`. Once granted, it holds ownership for a fixed burst of granted cycles, then releases the line for one mandatory gap cycle.
- Sits between job producers and the arbiter: `request` drives the arbiter, and the arbiter's `grant` returns here.

---
 rtl/req_grant_client_if.sv | 31 +++
 rtl/req_grant_client.sv | 158 +++++++++++++++
 tb/tb_req_grant_client.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/req_grant_client_if.sv
// req_grant_client_if
//   Bundles the job-producer and arbiter signals of the request/grant client.
//   job_valid : producer -> client  per-channel job offer
//   job_ready : client -> producer  per-channel queue-not-full
//   grant     : arbiter -> client   grant vector
//   request   : client -> arbiter   registered request lines
//   busy      : client -> outside   channel owns resource and is granted now
//   done      : client -> outside   one-cycle burst-complete pulse
//   err       : client -> outside   sticky protocol error
// Modports: slave = the client block, master = the surrounding logic/bench.
interface req_grant_client_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] job_valid;
  logic [N_CH-1:0] job_ready;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] request;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;
  logic            err;

  modport master (
    output job_valid, grant,
    input  job_ready, request, busy, done, err
  );

  modport slave (
    input  job_valid, grant,
    output job_ready, request, busy, done, err
  );
endinterface

// File: rtl/req_grant_client.sv
// req_grant_client
//   Requester side of the N_CH-channel request/grant handshake. Each channel
//   queues up to MAX_PEND jobs, requests the arbiter, owns the resource for
//   BURST_LEN granted cycles per job, then drops request for one gap cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : req_grant_client_if.slave (job_valid/job_ready, grant/request,
//         busy, done, err)
// Build option:
//   REQ_GRANT_CHECK_EN - when defined, err flags grant protocol violations
//   (sticky until rst); otherwise err is tied to 0.

// One channel: pend counter, burst counter and IDLE/REQ/BUSY/GAP FSM.
module req_grant_lane #(
  parameter int MAX_PEND  = 3,
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic job_valid_i,
  input  logic grant_i,
  output logic job_ready_o,
  output logic request_o,
  output logic busy_o,
  output logic done_o,
  output logic in_busy_o
);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          request_q;
  logic          accept;
  logic          handoff;

  // Queue side. The REQ->BUSY grant consumes one queued job.
  always_comb begin
    job_ready_o = !rst && (pend_q != PW'(MAX_PEND));
    accept      = job_valid_i && job_ready_o;
    handoff     = (state_q == S_REQ) && grant_i;
    pend_d      = pend_q;
    case ({accept, handoff})
      2'b10:   pend_d = pend_q + PW'(1);
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: if (pend_q != '0) state_d = S_REQ;
      S_REQ: begin
        // The accepting grant is a handshake, not a burst cycle.
        if (grant_i) begin
          state_d = S_BUSY;
          burst_d = BW'(BURST_LEN);
        end
      end
      S_BUSY: begin
        // Preempted cycles (grant low) leave the count frozen.
        if (grant_i) begin
          burst_d = burst_q - BW'(1);
          if (burst_q == BW'(1)) state_d = S_GAP;
        end
      end
      S_GAP: state_d = (pend_d != '0) ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      burst_q   <= '0;
      request_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      burst_q   <= burst_d;
      request_q <= (state_d == S_REQ) || (state_d == S_BUSY);
    end
  end

  assign request_o = request_q;
  assign busy_o    = (state_q == S_BUSY) && grant_i;
  assign done_o    = (state_q == S_GAP);
  assign in_busy_o = (state_q == S_BUSY);
endmodule

module req_grant_client #(
  parameter int N_CH      = 4,
  parameter int MAX_PEND  = 3,
  parameter int BURST_LEN = 4
) (
  input logic               clk,
  input logic               rst,
  req_grant_client_if.slave bus
);
  logic [N_CH-1:0] in_busy;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_lane
      req_grant_lane #(
        .MAX_PEND  (MAX_PEND),
        .BURST_LEN (BURST_LEN)
      ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .job_valid_i (bus.job_valid[g]),
        .grant_i     (bus.grant[g]),
        .job_ready_o (bus.job_ready[g]),
        .request_o   (bus.request[g]),
        .busy_o      (bus.busy[g]),
        .done_o      (bus.done[g]),
        .in_busy_o   (in_busy[g])
      );
    end
  endgenerate

`ifdef REQ_GRANT_CHECK_EN
  logic            err_q, err_d;
  logic [N_CH-1:0] orphan;
  logic            multi;
  logic            drop_viol;

  // orphan: grant on a channel that is not requesting.
  always_comb begin
    orphan    = bus.grant & ~bus.request;
    multi     = (bus.grant & (bus.grant - N_CH'(1))) != '0;
    drop_viol = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_busy[i] && !bus.grant[i] && ((orphan & ~(N_CH'(1) << i)) != '0))
        drop_viol = 1'b1;
    end
    err_d = err_q || (orphan != '0) || multi || drop_viol;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  logic unused_in_busy;
  assign unused_in_busy = ^in_busy;
  assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_req_grant_client.sv
// Directed bench for req_grant_client (N_CH=4, MAX_PEND=3, BURST_LEN=4).
// Grant is either driven directly (gman) or mirrors request through gmask.
module tb_req_grant_client;
  logic clk = 1'b0;
  logic rst;
  logic       auto_g;
  logic [3:0] gmask, gman;
  int n_run  = 0;
  int n_fail = 0;

`ifdef REQ_GRANT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  req_grant_client_if #(.N_CH(4)) bus ();

  req_grant_client #(.N_CH(4), .MAX_PEND(3), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb bus.grant = auto_g ? (bus.request & gmask) : gman;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; auto_g = 1'b0; gmask = 4'hF; gman = 4'h0;
    bus.job_valid = 4'hF;

    // Reset with offers pending: nothing accepted, all outputs low.
    step();
    chk("rst_request", 8'(bus.request), 8'h0);
    chk("rst_done", 8'(bus.done), 8'h0);
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_ready", 8'(bus.job_ready), 8'h0);
    chk("rst_err", 8'(bus.err), 8'h0);
    step();
    chk("rst_ready2", 8'(bus.job_ready), 8'h0);
    rst = 1'b0; bus.job_valid = 4'h0;
    #1;
    chk("post_rst_ready", 8'(bus.job_ready), 8'hF);

    // Single job on channel 0 with immediate grants.
    auto_g = 1'b1;
    bus.job_valid = 4'h1;
    step();
    bus.job_valid = 4'h0;
    chk("c0_req_k", 8'(bus.request), 8'h0);
    step();
    chk("c0_req_k1", 8'(bus.request), 8'h1);
    chk("c0_busy_k1", 8'(bus.busy), 8'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("c0_busy", 8'(bus.busy), 8'h1);
      chk("c0_req_busy", 8'(bus.request), 8'h1);
      chk("c0_done_early", 8'(bus.done), 8'h0);
    end
    step();
    chk("c0_done", 8'(bus.done), 8'h1);
    chk("c0_gap_req", 8'(bus.request), 8'h0);
    chk("c0_gap_busy", 8'(bus.busy), 8'h0);
    step();
    chk("c0_done_once", 8'(bus.done), 8'h0);
    chk("c0_req_after", 8'(bus.request), 8'h0);
    step();
    chk("c0_req_idle", 8'(bus.request), 8'h0);

    // Queue full on channel 2, no grant.
    auto_g = 1'b0; gman = 4'h0;
    bus.job_valid = 4'h4;
    #1;
    chk("q_ready0", 8'(bus.job_ready), 8'hF);
    step();
    chk("q_ready1", 8'(bus.job_ready), 8'hF);
    step();
    chk("q_ready2", 8'(bus.job_ready), 8'hF);
    step();
    chk("q_ready3", 8'(bus.job_ready), 8'hB);
    step();
    chk("q_reject", 8'(bus.job_ready), 8'hB);
    bus.job_valid = 4'h0;
    chk("q_req", 8'(bus.request), 8'h4);
    // Continuous grant drains three jobs; gaps at steps 5, 11, 17.
    auto_g = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      step();
      chk("q_done", 8'(bus.done), (s == 5 || s == 11 || s == 17) ? 8'h4 : 8'h0);
      chk("q_req_seq", 8'(bus.request), (s == 5 || s == 11 || s >= 17) ? 8'h0 : 8'h4);
    end

    // Preemption on channel 1 with burst_cnt=2.
    gmask = 4'hF;
    bus.job_valid = 4'h2;
    step();
    bus.job_valid = 4'h0;
    step();
    step();
    chk("p_busy_first", 8'(bus.busy), 8'h2);
    step();
    step();
    chk("p_busy_cnt2", 8'(bus.busy), 8'h2);
    gmask = 4'hD;
    #1;
    chk("p_pre_busy0", 8'(bus.busy), 8'h0);
    chk("p_pre_req", 8'(bus.request), 8'h2);
    step();
    chk("p_pre_busy1", 8'(bus.busy), 8'h0);
    chk("p_pre_done1", 8'(bus.done), 8'h0);
    step();
    chk("p_pre_busy2", 8'(bus.busy), 8'h0);
    chk("p_pre_done2", 8'(bus.done), 8'h0);
    step();
    gmask = 4'hF;
    #1;
    chk("p_resume_busy", 8'(bus.busy), 8'h2);
    step();
    chk("p_busy_last", 8'(bus.busy), 8'h2);
    chk("p_done_not_yet", 8'(bus.done), 8'h0);
    step();
    chk("p_done", 8'(bus.done), 8'h2);
    chk("p_done_busy", 8'(bus.busy), 8'h0);

    // Accept and grant on the same edge for channel 3 (pend=1).
    auto_g = 1'b0; gman = 4'h0;
    step();
    bus.job_valid = 4'h8;
    step();
    bus.job_valid = 4'h0;
    step();
    chk("s_req", 8'(bus.request), 8'h8);
    bus.job_valid = 4'h8; gman = 4'h8;
    #1;
    chk("s_req_busy0", 8'(bus.busy), 8'h0);
    step();
    gman = 4'h0;
    #1;
    chk("s_pend1_ready", 8'(bus.job_ready), 8'hF);
    chk("s_preempt", 8'(bus.busy), 8'h0);
    step();
    chk("s_pend2_ready", 8'(bus.job_ready), 8'hF);
    step();
    chk("s_pend3_ready", 8'(bus.job_ready), 8'h7);
    bus.job_valid = 4'h0;
    auto_g = 1'b1; gmask = 4'hF;
    #1;
    chk("s_busy0", 8'(bus.busy), 8'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_busy", 8'(bus.busy), 8'h8);
    end
    step();
    chk("s_done", 8'(bus.done), 8'h8);
    chk("s_gap_req", 8'(bus.request), 8'h0);
    step();
    chk("s_back_req", 8'(bus.request), 8'h8);
    chk("s_back_done", 8'(bus.done), 8'h0);
    chk("s_back_ready", 8'(bus.job_ready), 8'h7);

    // Reset mid-burst discards everything, no done.
    step();
    rst = 1'b1;
    step();
    chk("mr_req", 8'(bus.request), 8'h0);
    chk("mr_done", 8'(bus.done), 8'h0);
    chk("mr_ready", 8'(bus.job_ready), 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_req_after", 8'(bus.request), 8'h0);
      chk("mr_done_after", 8'(bus.done), 8'h0);
    end
    chk("mr_ready_after", 8'(bus.job_ready), 8'hF);

    // Protocol error: grant 4'b0011 with only request[0] high.
    auto_g = 1'b0; gman = 4'h0;
    bus.job_valid = 4'h1;
    step();
    bus.job_valid = 4'h0;
    step();
    chk("e_req", 8'(bus.request), 8'h1);
    chk("e_err_clean", 8'(bus.err), 8'h0);
    gman = 4'h3;
    step();
    chk("e_err_set", 8'(bus.err), 8'(ERR_EXP));
    gman = 4'h0;
    step();
    chk("e_err_sticky", 8'(bus.err), 8'(ERR_EXP));
    rst = 1'b1;
    step();
    chk("e_err_rst", 8'(bus.err), 8'h0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
